// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the write-back port arbiter: FSM state encoding,
// default widths and the wait-counter width.
package wb_port_arbiter_pkg;

    // Buffer occupancy states; encoding is fixed so debug tooling can decode it.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,   // buffer empty, debug writes accepted
        ST_PEND  = 2'b01,   // buffer full, waiting for a free port cycle
        ST_FORCE = 2'b10    // buffer full, upstream stages frozen
    } arb_state_t;

    localparam int NB_DATA_DEF  = 32;
    localparam int NB_REG_DEF   = 5;
    localparam int MAX_WAIT_DEF = 8;
    localparam int WAIT_CNT_W   = 8;

endpackage

// File: rtl/mux2.sv
// Generic two-input multiplexer: out = sel ? in1 : in0.
module mux2 #(
    parameter int WIDTH = 32
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] out
);

    assign out = sel ? in1 : in0;

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the pipeline
// write-back stage (always first) and a one-entry debug write buffer.
// A debug write blocked for MAX_WAIT cycles freezes the upstream pipeline
// until the port frees up.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int NB_DATA  = NB_DATA_DEF,
    parameter int NB_REG   = NB_REG_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_wb_reg_write,
    input  logic [NB_REG-1:0]  i_wb_reg,
    input  logic [NB_DATA-1:0] i_wb_data,
    input  logic               i_dbg_valid,
    input  logic [NB_REG-1:0]  i_dbg_reg,
    input  logic [NB_DATA-1:0] i_dbg_data,
    output logic               o_dbg_ready,
    output logic               o_dbg_done,
    output logic               o_rf_write,
    output logic [NB_REG-1:0]  o_rf_reg,
    output logic [NB_DATA-1:0] o_rf_data,
    output logic               o_stall
);

    // Counter value at which the next blocked cycle escalates to FORCE.
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MAX_WAIT - 1);

    arb_state_t              state_r;
    logic [NB_REG-1:0]       buf_reg_r;
    logic [NB_DATA-1:0]      buf_data_r;
    logic [WAIT_CNT_W-1:0]   wait_cnt_r;

    logic                    wb_busy_s;
    logic                    buf_full_s;
    logic                    issue_s;
    logic                    buf_live_s;
    logic [NB_DATA-1:0]      mux_data_s;

    // A write to r0 is a no-op, so it does not occupy the port.
    assign wb_busy_s  = i_wb_reg_write && (i_wb_reg != {NB_REG{1'b0}});
    assign buf_full_s = (state_r != ST_IDLE);
    // The buffered write goes out in any cycle the pipeline leaves the port free.
    assign issue_s    = buf_full_s && !wb_busy_s;
    assign buf_live_s = (buf_reg_r != {NB_REG{1'b0}});

    assign o_dbg_ready = (state_r == ST_IDLE);
    assign o_stall     = (state_r == ST_FORCE);

    mux2 #(
        .WIDTH (NB_DATA)
    ) u_data_mux (
        .sel (wb_busy_s),
        .in0 (buf_data_r),
        .in1 (i_wb_data),
        .out (mux_data_s)
    );

    // Steer the write port: pipeline first, then the buffer, else all zero.
    always_comb begin
        o_rf_write = 1'b0;
        o_rf_reg   = {NB_REG{1'b0}};
        o_rf_data  = {NB_DATA{1'b0}};
        o_dbg_done = 1'b0;
        if (wb_busy_s) begin
            o_rf_write = 1'b1;
            o_rf_reg   = i_wb_reg;
            o_rf_data  = mux_data_s;
        end else if (issue_s) begin
            o_dbg_done = 1'b1;
            if (buf_live_s) begin
                o_rf_write = 1'b1;
                o_rf_reg   = buf_reg_r;
                o_rf_data  = mux_data_s;
            end else begin
                o_rf_write = 1'b0;
                o_rf_reg   = {NB_REG{1'b0}};
                o_rf_data  = {NB_DATA{1'b0}};
            end
        end else begin
            o_rf_write = 1'b0;
            o_rf_reg   = {NB_REG{1'b0}};
            o_rf_data  = {NB_DATA{1'b0}};
        end
    end

    // Buffer FSM: capture, wait-cycle counting, stall escalation and release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= ST_IDLE;
            buf_reg_r  <= {NB_REG{1'b0}};
            buf_data_r <= {NB_DATA{1'b0}};
            wait_cnt_r <= {WAIT_CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    wait_cnt_r <= {WAIT_CNT_W{1'b0}};
                    if (i_dbg_valid) begin
                        buf_reg_r  <= i_dbg_reg;
                        buf_data_r <= i_dbg_data;
                        state_r    <= ST_PEND;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_PEND: begin
                    if (!wb_busy_s) begin
                        state_r    <= ST_IDLE;
                        wait_cnt_r <= {WAIT_CNT_W{1'b0}};
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        state_r    <= ST_FORCE;
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end else begin
                        state_r    <= ST_PEND;
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                ST_FORCE: begin
                    if (!wb_busy_s) begin
                        state_r    <= ST_IDLE;
                        wait_cnt_r <= {WAIT_CNT_W{1'b0}};
                    end else begin
                        state_r    <= ST_FORCE;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    wait_cnt_r <= {WAIT_CNT_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter NB_DATA, default 32, register-file data width.
REQ-002 SHALL have parameter NB_REG, default 5, register address width.
REQ-003 SHALL have parameter MAX_WAIT, default 8, number of blocked cycles before the pipeline stall is forced (range 1..255).
REQ-004 SHALL have port i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_wb_reg_write  input  1  write-back stage requests a register write.
REQ-007 SHALL have port i_wb_reg  input  NB_REG  write-back destination register.
REQ-008 SHALL have port i_wb_data  input  NB_DATA  write-back data.
REQ-009 SHALL have port i_dbg_valid  input  1  debug unit offers a register write.
REQ-010 SHALL have port i_dbg_reg  input  NB_REG  debug destination register.
REQ-011 SHALL have port i_dbg_data  input  NB_DATA  debug write data.
REQ-012 SHALL have port o_dbg_ready  output  1  arbiter can accept a debug write.
REQ-013 SHALL have port o_dbg_done  output  1  one-cycle pulse: buffered debug write issued.
REQ-014 SHALL have port o_rf_write  output  1  register-file write enable.
REQ-015 SHALL have port o_rf_reg  output  NB_REG  register-file write address.
REQ-016 SHALL have port o_rf_data  output  NB_DATA  register-file write data.
REQ-017 SHALL have port o_stall  output  1  request to freeze stages upstream of write-back.

Function
REQ-018 SHALL implement states IDLE (buffer empty), PEND (buffer full, waiting), FORCE (buffer full, stall asserted).
REQ-019 SHALL drive o_dbg_ready = 1 only in IDLE (registered state, no combinational path from i_dbg_valid).
REQ-020 SHALL capture i_dbg_reg/i_dbg_data into a one-entry buffer and enter PEND on an edge where i_dbg_valid && o_dbg_ready.
REQ-021 SHALL treat the pipeline as occupying the port only when i_wb_reg_write=1 and i_wb_reg!=0 ("wb_busy").
REQ-022 SHALL pass the pipeline write combinationally (zero latency) when wb_busy: o_rf_write=1, o_rf_reg=i_wb_reg, o_rf_data=i_wb_data; the pipeline always has priority.
REQ-023 SHALL, in PEND or FORCE with wb_busy=0, issue the buffered write in that same cycle (o_rf_* from buffer, o_dbg_done=1) and go to IDLE.
REQ-024 SHALL never issue a debug write in the cycle it is accepted; earliest issue is the following cycle.
REQ-025 SHALL suppress o_rf_write for a buffered write targeting register 0 while still pulsing o_dbg_done and returning to IDLE.
REQ-026 SHALL, in PEND with wb_busy=1, increment an 8-bit wait counter and go to FORCE when the counter reaches MAX_WAIT.
REQ-027 SHALL assert o_stall combinationally in FORCE only, deasserting in the cycle after the buffered write issues.
REQ-028 SHALL clear the wait counter on every transition into IDLE.
REQ-029 SHALL drive o_rf_write=0, o_dbg_done=0 and o_rf_reg/o_rf_data=0 when neither source writes.
REQ-030 SHALL preserve order for same-register collisions: a pipeline write in the same cycle as a pending debug write lands first; the debug write lands later and wins.

Reset
REQ-031 SHALL on i_rst_n=0, immediately and regardless of state, enter IDLE, empty the buffer, clear the counter, and drive o_dbg_ready=1, o_stall=0, o_dbg_done=0.
REQ-032 SHALL silently discard a pending debug write when reset is asserted mid-operation (no o_dbg_done).
REQ-033 SHALL keep the pipeline pass-through (REQ-022) combinational during reset; o_rf_write follows wb_busy.

Structure
REQ-034 SHALL place the state encoding (IDLE=2'b00, PEND=2'b01, FORCE=2'b10) and default widths in a shared package/header used by the pipeline top.
REQ-035 SHALL reuse the existing mux2 module for the o_rf_data selection between buffer and i_wb_data.

Verification
REQ-036 SHALL cover: idle port, dbg write r5=0xDEADBEEF -> accepted at edge N, o_rf_write r5 and o_dbg_done in cycle N+1, o_dbg_ready=1 at N+2.
REQ-037 SHALL cover: wb_busy held 3 cycles after acceptance -> pipeline writes pass through unchanged, debug issues in cycle 4, no o_stall.
REQ-038 SHALL cover: wb_busy held continuously, MAX_WAIT=8 -> o_stall asserted after 8 blocked cycles; issue on first wb_busy=0 cycle; o_stall low next cycle.
REQ-039 SHALL cover: pipeline r3=0x1 and pending debug r3=0x2 -> r3 final value 0x2.
REQ-040 SHALL cover: debug write to r0 -> o_rf_write=0, o_dbg_done=1; pipeline write to r0 -> counted as idle, pending debug issues.
REQ-041 SHALL cover: i_rst_n pulsed low in FORCE -> o_stall=0 and o_dbg_ready=1 immediately, no o_dbg_done afterwards.
